pcie_tx_lane_sched: RTL and testbench

TX-side scheduler that feeds the 128-bit PHY byte-striping stage. Each cycle it picks one beat to drive onto the stripe datapath from four sources: a multi-beat TLP stream, single-beat DLLPs, a periodically inserted SKP ordered set, or idle. Selection happens only at packet boundaries, and the chosen beat is registered before it reaches the striper. The block sits between the data-link-layer TX mux and the PHY byte-stripe/lane logic.

---
 rtl/pcie_tx_lane_sched.sv | 124 ++++++++++++
 tb/tb_pcie_tx_lane_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_lane_sched.sv
// TX beat scheduler ahead of the 128-bit PHY byte striper.
// Picks SKP, DLLP, TLP or idle at packet boundaries and registers the chosen beat.
module pcie_tx_lane_sched #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned SKP_INTERVAL   = 1180,
  parameter int unsigned DLLP_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  link_up,
  input  logic                  tlp_valid,
  input  logic [DATA_WIDTH-1:0] tlp_data,
  input  logic                  tlp_last,
  output logic                  tlp_ready,
  input  logic                  dllp_valid,
  input  logic [DATA_WIDTH-1:0] dllp_data,
  output logic                  dllp_ready,
  output logic [DATA_WIDTH-1:0] stripe_data,
  output logic                  stripe_valid,
  output logic [1:0]            stripe_kind,
  output logic                  tx_underrun
);

  localparam int unsigned CNT_W   = $clog2(SKP_INTERVAL);
  localparam int unsigned BURST_W = $clog2(DLLP_BURST_MAX + 1);
  localparam logic [CNT_W-1:0]      SKP_LAST  = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [BURST_W-1:0]    BURST_MAX = BURST_W'(DLLP_BURST_MAX);
  localparam logic [DATA_WIDTH-1:0] SKP_BEAT  = {(DATA_WIDTH / 32){32'h1C1C1CBC}};

  localparam logic [1:0] KIND_IDLE = 2'b00;
  localparam logic [1:0] KIND_TLP  = 2'b01;
  localparam logic [1:0] KIND_DLLP = 2'b10;
  localparam logic [1:0] KIND_SKP  = 2'b11;

  typedef enum logic {ARB, TLP_BUSY} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      skp_cnt_q, skp_cnt_d;
  logic                  skp_pending_q, skp_pending_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [1:0]            kind_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  underrun_d;
  logic                  skp_wrap;
  logic                  skp_taken;

  // Arbitration: readies are combinational, everything else is the next registered value.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    kind_d     = KIND_IDLE;
    data_d     = '0;
    underrun_d = tx_underrun;
    tlp_ready  = 1'b0;
    dllp_ready = 1'b0;
    skp_taken  = 1'b0;
    skp_wrap   = (skp_cnt_q == SKP_LAST);

    if (!link_up) begin
      state_d = ARB;
      burst_d = '0;
      if (state_q == TLP_BUSY) underrun_d = 1'b1;
    end else if (state_q == TLP_BUSY) begin
      tlp_ready = reset_n;
      if (tlp_valid) begin
        kind_d = KIND_TLP;
        data_d = tlp_data;
        if (tlp_last) state_d = ARB;
      end else begin
        underrun_d = 1'b1;
      end
    end else begin
      if (skp_pending_q) begin
        kind_d    = KIND_SKP;
        data_d    = SKP_BEAT;
        skp_taken = 1'b1;
      end else if (dllp_valid && !(burst_q == BURST_MAX && tlp_valid)) begin
        dllp_ready = reset_n;
        kind_d     = KIND_DLLP;
        data_d     = dllp_data;
        if (tlp_valid && burst_q != BURST_MAX) burst_d = burst_q + BURST_W'(1);
      end else if (tlp_valid) begin
        tlp_ready = reset_n;
        kind_d    = KIND_TLP;
        data_d    = tlp_data;
        burst_d   = '0;
        if (!tlp_last) state_d = TLP_BUSY;
      end
      if (!tlp_valid) burst_d = '0;
    end

    // A wrap coinciding with a SKP emission keeps one SKP pending.
    if (!link_up) begin
      skp_cnt_d     = '0;
      skp_pending_d = 1'b0;
    end else begin
      skp_cnt_d     = skp_wrap ? '0 : skp_cnt_q + CNT_W'(1);
      skp_pending_d = skp_wrap || (skp_pending_q && !skp_taken);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB;
      skp_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
      burst_q       <= '0;
      stripe_data   <= '0;
      stripe_valid  <= 1'b0;
      stripe_kind   <= KIND_IDLE;
      tx_underrun   <= 1'b0;
    end else begin
      state_q       <= state_d;
      skp_cnt_q     <= skp_cnt_d;
      skp_pending_q <= skp_pending_d;
      burst_q       <= burst_d;
      stripe_data   <= data_d;
      stripe_valid  <= (kind_d != KIND_IDLE);
      stripe_kind   <= kind_d;
      tx_underrun   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pcie_tx_lane_sched.sv
// Randomized scoreboard bench for pcie_tx_lane_sched against a cycle-count reference model.
module tb_pcie_tx_lane_sched;

  localparam int unsigned DW   = 128;
  localparam int unsigned SKP  = 8;
  localparam int unsigned BMAX = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          link_up = 1'b0;
  logic          tlp_valid = 1'b0;
  logic [DW-1:0] tlp_data = '0;
  logic          tlp_last = 1'b0;
  logic          tlp_ready;
  logic          dllp_valid = 1'b0;
  logic [DW-1:0] dllp_data = '0;
  logic          dllp_ready;
  logic [DW-1:0] stripe_data;
  logic          stripe_valid;
  logic [1:0]    stripe_kind;
  logic          tx_underrun;

  always #5 clk = ~clk;

  pcie_tx_lane_sched #(
    .DATA_WIDTH(DW), .SKP_INTERVAL(SKP), .DLLP_BURST_MAX(BMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .link_up(link_up),
    .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ready(tlp_ready),
    .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(dllp_ready),
    .stripe_data(stripe_data), .stripe_valid(stripe_valid), .stripe_kind(stripe_kind),
    .tx_underrun(tx_underrun)
  );

  typedef struct packed {
    logic [1:0]    kind;
    logic          urun;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: SKP timing derived from cycles elapsed since link-up/reset.
  bit          m_busy, m_pend, m_urun;
  int unsigned m_cyc, m_burst;

  // Traffic sources
  bit            s_act, d_act;
  int unsigned   s_len, s_idx;
  logic [DW-1:0] s_data, d_data;
  int unsigned   tlp_pct, dllp_pct, drop_pct;
  bit            bubble_req, bubble_done;

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_urun = 0; m_cyc = 0; m_burst = 0;
    s_act = 0; d_act = 0;
  endtask

  task automatic model_step(input bit link, input bit tv, input bit tl, input logic [DW-1:0] td,
                            input bit dv, input logic [DW-1:0] dd, output bit tr, output bit dr);
    exp_t e;
    bit   wrap, took_skp;
    e = '0; tr = 0; dr = 0; took_skp = 0;
    wrap = (m_cyc % SKP) == SKP - 1;
    if (!link) begin
      if (m_busy) m_urun = 1;
      m_busy = 0; m_pend = 0; m_cyc = 0; m_burst = 0;
    end else begin
      if (m_busy) begin
        tr = 1;
        if (tv) begin
          e.kind = 2'd1; e.data = td;
          if (tl) m_busy = 0;
        end else m_urun = 1;
      end else begin
        if (m_pend) begin
          e.kind = 2'd3; e.data = {4{32'h1C1C1CBC}}; took_skp = 1;
        end else if (dv && !(m_burst == BMAX && tv)) begin
          dr = 1; e.kind = 2'd2; e.data = dd;
          if (tv && m_burst < BMAX) m_burst++;
        end else if (tv) begin
          tr = 1; e.kind = 2'd1; e.data = td; m_burst = 0;
          if (!tl) m_busy = 1;
        end
        if (!tv) m_burst = 0;
      end
      m_pend = wrap || (m_pend && !took_skp);
      m_cyc++;
    end
    e.urun = m_urun;
    exp_q.push_back(e);
  endtask

  // Entered at a negedge: present inputs, predict, check readies, advance to next negedge.
  task automatic drive_cycle();
    bit tv, tr, dr, link;
    if (!s_act && $urandom_range(99) < tlp_pct) begin
      s_act = 1; s_len = $urandom_range(4, 1); s_idx = 0; s_data = rnd();
    end
    if (!d_act && $urandom_range(99) < dllp_pct) begin
      d_act = 1; d_data = rnd();
    end
    link = !($urandom_range(99) < drop_pct);
    tv = s_act;
    if (bubble_req && m_busy && s_idx == 1) begin
      tv = 0; bubble_req = 0; bubble_done = 1;
      if (!d_act) begin d_act = 1; d_data = rnd(); end
    end
    link_up = link; tlp_valid = tv; tlp_data = s_data; tlp_last = (s_idx == s_len - 1);
    dllp_valid = d_act; dllp_data = d_data;
    #1;
    model_step(link, tv, tlp_last, s_data, d_act, d_data, tr, dr);
    chk("tlp_ready", DW'(tlp_ready), DW'(tr));
    chk("dllp_ready", DW'(dllp_ready), DW'(dr));
    if (tv && tr) begin
      s_idx++;
      if (s_idx == s_len) s_act = 0;
      else s_data = rnd();
    end
    if (d_act && dr) d_act = 0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, stripe_data, '0);
    chk({tag, "_valid"}, DW'(stripe_valid), '0);
    chk({tag, "_kind"}, DW'(stripe_kind), '0);
    chk({tag, "_underrun"}, DW'(tx_underrun), '0);
    chk({tag, "_tlp_ready"}, DW'(tlp_ready), '0);
    chk({tag, "_dllp_ready"}, DW'(dllp_ready), '0);
  endtask

  // Monitor: one registered beat per clock, compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stripe_kind", DW'(stripe_kind), DW'(e.kind));
        chk("stripe_data", stripe_data, e.data);
        chk("stripe_valid", DW'(stripe_valid), DW'(e.kind != 2'd0));
        chk("tx_underrun", DW'(tx_underrun), DW'(e.urun));
      end
    end
  end

  initial begin
    model_reset();
    bubble_req = 0; bubble_done = 0;
    tlp_pct = 0; dllp_pct = 0; drop_pct = 0;
    link_up = 1; tlp_valid = 1; tlp_last = 0; dllp_valid = 1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1;

    // Idle link: SKP every SKP cycles, idle otherwise
    for (int i = 0; i < 20; i++) drive_cycle();

    // Mixed random traffic, well-formed packets
    tlp_pct = 40; dllp_pct = 40;
    for (int i = 0; i < 200; i++) drive_cycle();

    // Saturated sources: DLLP burst limit against waiting TLPs
    tlp_pct = 100; dllp_pct = 100;
    for (int i = 0; i < 60; i++) drive_cycle();

    // Mid-TLP bubble
    dllp_pct = 0; bubble_req = 1;
    for (int i = 0; i < 40; i++) drive_cycle();
    if (bubble_done) chk("underrun_sticky", DW'(tx_underrun), DW'(1));

    // Reset asserted inside a multi-beat TLP
    for (int i = 0; i < 50 && !m_busy; i++) drive_cycle();
    #2;
    reset_n = 0;
    exp_q.delete();
    model_reset();
    #1;
    check_all_zero("midpkt_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 10; i++) drive_cycle();

    // Random traffic with link drops
    tlp_pct = 50; dllp_pct = 40; drop_pct = 8;
    for (int i = 0; i < 200; i++) drive_cycle();
    drop_pct = 0;
    for (int i = 0; i < 10; i++) drive_cycle();

    @(posedge clk);
    #2;
    chk("queue_drained", DW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
